// File: rtl/input_debouncer.sv
// Raw input conditioner: synchronizer chain followed by a four-state debounce FSM.
// Emits a registered debounced level plus single-cycle rise/fall strobes.
module input_debouncer #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CNT = 4,
  parameter int CNT_W        = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic Raw_In,
  output logic Out1,
  output logic Rise,
  output logic Fall
);

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_out_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], Raw_In};
    end
  end

  // State register; outputs are registered here so nothing from Raw_In
  // reaches a port combinationally.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= LOW;
      r_cnt   <= '0;
      Out1    <= 1'b0;
      Rise    <= 1'b0;
      Fall    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      Out1    <= w_out_nxt;
      Rise    <= w_rise_nxt;
      Fall    <= w_fall_nxt;
    end
  end

  always_comb begin
    w_state_nxt = LOW;
    w_cnt_nxt   = '0;
    case (r_state)
      LOW: begin
        if (w_s) begin
          w_state_nxt = RISE_CHK;
          w_cnt_nxt   = ONE;
        end
      end
      RISE_CHK: begin
        if (!w_s) begin
          w_state_nxt = LOW;
        end else if (r_cnt == LAST) begin
          w_state_nxt = HIGH;
        end else begin
          w_state_nxt = RISE_CHK;
          w_cnt_nxt   = r_cnt + ONE;
        end
      end
      HIGH: begin
        w_state_nxt = HIGH;
        if (!w_s) begin
          w_state_nxt = FALL_CHK;
          w_cnt_nxt   = ONE;
        end
      end
      FALL_CHK: begin
        if (w_s) begin
          w_state_nxt = HIGH;
        end else if (r_cnt == LAST) begin
          w_state_nxt = LOW;
        end else begin
          w_state_nxt = FALL_CHK;
          w_cnt_nxt   = r_cnt + ONE;
        end
      end
      default: begin
        w_state_nxt = LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_out_nxt  = 1'b0;
    w_rise_nxt = 1'b0;
    w_fall_nxt = 1'b0;
    case (r_state)
      LOW:      w_out_nxt = 1'b0;
      HIGH:     w_out_nxt = 1'b1;
      RISE_CHK: begin
        w_rise_nxt = w_s && (r_cnt == LAST);
        w_out_nxt  = w_rise_nxt;
      end
      FALL_CHK: begin
        w_fall_nxt = !w_s && (r_cnt == LAST);
        w_out_nxt  = !w_fall_nxt;
      end
      default: begin
        w_out_nxt  = 1'b0;
        w_rise_nxt = 1'b0;
        w_fall_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Conditions a raw, asynchronous, possibly bouncing single-bit input into a clean, clock-synchronous level for the Moore sequence FSM that consumes it on its `In1` input. The block has a multi-stage synchronizer, then a four-state debounce machine with a stability counter. It produces a debounced level plus single-cycle rise and fall strobes. It sits directly upstream of the FSM, and its `Out1` connects to the FSM's `In1`.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops. Legal range is 2..4.
- `DEBOUNCE_CNT`, default 4: number of consecutive identical synchronized samples needed to accept a level change. Must be at least 2.
- `CNT_W`, default 16: stability counter width. Requires DEBOUNCE_CNT ≤ 2^CNT_W.
- One clock; reset is synchronous and active-high.
- `CLK`  in  1  system clock. Everything updates on its rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `Raw_In`  in  1  raw asynchronous input (switch or pin).
- `Out1`  out  1  debounced level, registered. Drives the FSM's `In1`.
- `Rise`  out  1  one-cycle strobe, asserted on the edge where `Out1` goes 0→1.
- `Fall`  out  1  one-cycle strobe, asserted on the edge where `Out1` goes 1→0.

## Operation
- **Synchronizer**
  - `Raw_In` is shifted through SYNC_STAGES flops.
  - The last stage is `s`. Only `s` is used by the logic below.
- **States:** LOW, RISE_CHK, HIGH, FALL_CHK.
- **Stability counter:** `cnt` counts accepted samples within a CHK state.
- **LOW** (`Out1`=0)
  - If s=1, go to RISE_CHK with cnt=1.
  - Otherwise stay.
- **RISE_CHK**
  - s=0: go back to LOW and set cnt=0. No strobe.
  - s=1 and cnt=DEBOUNCE_CNT-1: go to HIGH, set `Out1`=1, pulse `Rise`, set cnt=0.
  - s=1 otherwise: increment cnt.
- **HIGH** (`Out1`=1)
  - If s=0, go to FALL_CHK with cnt=1.
  - Otherwise stay.
- **FALL_CHK**
  - s=1: go back to HIGH and set cnt=0. No strobe.
  - s=0 and cnt=DEBOUNCE_CNT-1: go to LOW, set `Out1`=0, pulse `Fall`, set cnt=0.
  - s=0 otherwise: increment cnt.
- **Output during CHK states:** `Out1` holds its previous value throughout both CHK states. A bounce never toggles it.
- **Counter width:** cnt never exceeds DEBOUNCE_CNT-1, so it cannot wrap.
- **Illegal state encodings:** any unused encoding goes to LOW on the next edge, with `Out1`=0, cnt=0 and no strobe.

## Timing
- **Reset** (RST=1 at a rising edge; takes priority over everything):
  - All synchronizer flops = 0, state = LOW, cnt = 0.
  - `Out1` = 0, `Rise` = 0, `Fall` = 0.
- **Reset mid-operation:**
  - Reset while in HIGH or FALL_CHK forces `Out1` to 0 with no `Fall` strobe.
  - Reset while in RISE_CHK aborts the check with no `Rise` strobe.
- **After reset release:** sampling resumes on the first edge with RST=0. The synchronizer refills over SYNC_STAGES edges.
- **Latency:** if `Raw_In` changes and stays stable, `Out1` changes on edge SYNC_STAGES+DEBOUNCE_CNT, counting the first edge that samples the new value as edge 1. With defaults this is edge 6.
- **Strobes:**
  - `Rise`/`Fall` are asserted on the same edge that updates `Out1`, and last exactly one cycle.
  - `Rise` and `Fall` are never both asserted.
  - Strobes are never asserted on consecutive cycles. Any two strobes are at least DEBOUNCE_CNT cycles apart.
- **Glitch rejection:** a run of fewer than DEBOUNCE_CNT identical samples at `s` has no effect on any output.
- **Run of exactly DEBOUNCE_CNT samples:** the level change is accepted.
- **Sample that breaks a run:** it restarts the check from the current stable state. The breaking sample itself does not count toward the opposite direction; detection restarts from LOW or HIGH on the next edge.
- **Outputs and the downstream FSM:** all outputs are flop outputs with no combinational path from `Raw_In`. They are safe to drive the downstream FSM directly.

## Test plan
Defaults (SYNC_STAGES=2, DEBOUNCE_CNT=4) unless stated otherwise.
1. **Reset:** assert RST for 2 cycles with `Raw_In`=1 → `Out1`=`Rise`=`Fall`=0 throughout reset. `Out1` rises 6 edges after RST drops.
2. **Clean rise and fall:** `Raw_In` goes 0→1 and holds → `Out1`=1 and `Rise`=1 for exactly one cycle at edge 6. Then `Raw_In` goes 1→0 → `Out1`=0 and a single `Fall` pulse at edge 6 of the low run.
3. **Glitch rejection:** `Raw_In` high for 3 cycles, then low → `Out1`, `Rise` and `Fall` stay 0. Then high for exactly 4 cycles → `Out1` rises at edge 6, and falls 4 edges later with one `Fall` pulse.
4. **Bounce:** the pattern 1,0,1,1,0,1,1,1,1 (then held) on `Raw_In` → exactly one `Rise`, on the edge after the fourth consecutive 1 has reached `s`. No `Fall` pulse.
5. **Reset mid-operation:**
   - Assert RST while in RISE_CHK (cnt=2) → no `Rise` strobe; state=LOW, `Out1`=0.
   - Assert RST while in HIGH → `Out1`=0 with no `Fall` strobe.
6. **Parameter sweep:** SYNC_STAGES=3, DEBOUNCE_CNT=2 → a step on `Raw_In` is reflected on `Out1` at edge 5. A 1-cycle pulse is rejected.
